tlv5618a_sched: RTL and testbench
=================================

// Module: tlv5618a_sched
// PURPOSE
//  Schedules 12-bit sample writes from two requesters (channel A, channel B) onto one TLV5618A
//  dual-DAC serial link. Holds one pending sample per channel, chooses the command word, and
//  shifts 16-bit frames MSB-first. Sits between the NCO sample sources and the DAC pins.
// PARAMETERS
//  CLK_DIV  4  clk cycles per SCLK half-period (>=1)
//  CS_GAP   2  clk cycles dac_csn held high between frames (>=1)
//  SPD      1  TLV5618A speed bit (1=fast), bit 14 of every word
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  a_data       in   12  channel A sample
//  a_valid      in   1   channel A sample offered
//  a_ready      out  1   channel A holding register empty
//  b_data       in   12  channel B sample
//  b_valid      in   1   channel B sample offered
//  b_ready      out  1   channel B holding register empty
//  dac_sclk     out  1   serial clock, idle high
//  dac_din      out  1   serial data, changes on SCLK rising, DAC samples on falling
//  dac_csn      out  1   frame select, active-low
//  busy         out  1   high when not IDLE
//  frame_done   out  1   1-cycle pulse when dac_csn returns high
// BEHAVIOUR
//  - Reset (rst high on an edge): dac_csn=1, dac_sclk=1, dac_din=0, busy=0, frame_done=0,
//    a_ready=b_ready=0 while rst high; pending flags cleared; mid-frame reset aborts frame.
//  - Handshake: x_ready = ~pend_x; accept on x_valid & x_ready at clk edge; pend_x set next cycle.
//    Simultaneous accept on both channels allowed. pend_x cleared in the LOAD cycle of its frame.
//  - Word = {R1, SPD, PWR=0, R0, data[11:0]}. R1R0: B-only=00 (latch B + buffer),
//    A=10 (latch A, update B from buffer), pair first=01 (buffer only).
//  - Buffer always equals last B value, so an A-only write re-latches B unchanged.
//  - FSM: IDLE -> LOAD -> SHIFT -> GAP -> (LOAD if second pair frame queued, else IDLE).
//    IDLE: if any pend, select per arbitration, go LOAD.
//    LOAD (1 cycle): shift reg <= word, dac_csn=0, dac_din=word[15], sclk high.
//    SHIFT: 32*CLK_DIV cycles; sclk falls after CLK_DIV cycles, rises after CLK_DIV more;
//      din advances on each rising edge; exits after 16th rising edge.
//    GAP: dac_csn=1, dac_din=0 for CS_GAP cycles; frame_done pulses first GAP cycle.
//  - dac_csn low for exactly 1+32*CLK_DIV cycles per frame.
//  - Samples arriving during a frame wait; no frame is cut short by new requests.
//  - Data unsigned, passed unmodified; no saturation or offset.
// CONFIGURATION
//  SCHED_PAIR_EN defined: if both pend in IDLE, send pair: B with R=01, then A with R=10,
//    back-to-back (GAP between), both outputs update together on the A frame. Both pend
//    flags cleared at first LOAD of pair. Single pending -> single-channel word.
//  SCHED_PAIR_EN undefined: one word per IDLE decision; when both pend, round-robin,
//    A served first after reset, then alternate from last served channel.
// TESTING
//  1 CLK_DIV=2: a_data=12'hABC pulse -> one frame 16'hCABC, csn low 65 cycles, frame_done once.
//  2 b_data=12'h123 only -> frame 16'h4123; b_ready low from accept until LOAD.
//  3 PAIR_EN, a=12'h789,b=12'h456 same cycle -> frames 16'h5456 then 16'hC789, csn high 2 cycles between.
//  4 No PAIR_EN, both pending repeatedly -> frames alternate A,B,A,B starting with A.
//  5 a_valid held with new data during frame -> a_ready low, second sample sent in next frame, none lost.
//  6 rst at bit 7 of frame -> next cycle csn=1,sclk=1,din=0, busy=0; no frame_done; pends cleared.

Source files
------------

// File: rtl/tlv5618a_sched.sv
// Two-channel sample scheduler feeding one TLV5618A dual DAC over its 16-bit serial link.
// Optional macro SCHED_PAIR_EN: when both channels are pending, send B (buffer) then A as a pair.
module tlv5618a_sched #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 2,
    parameter logic        SPD     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] a_data,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [11:0] b_data,
    input  logic        b_valid,
    output logic        b_ready,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        dac_csn,
    output logic        busy,
    output logic        frame_done
);
    localparam int unsigned PHW = $clog2(2 * CLK_DIV);
    localparam int unsigned GW  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PHW-1:0]  r_ph, w_ph_nxt;
    logic [3:0]      r_bit, w_bit_nxt;
    logic [GW-1:0]   r_gcnt, w_gcnt_nxt;
    logic [15:0]     r_sr, w_sr_nxt;
    logic            r_pend_a, r_pend_b;
    logic [11:0]     r_a_data, r_b_data;
    logic            w_clr_a, w_clr_b;
    logic            r_sclk, r_din, r_csn, r_done;
    logic            w_sclk_nxt, w_din_nxt, w_csn_nxt, w_done_nxt;
`ifdef SCHED_PAIR_EN
    logic            r_pair_q, w_pair_q_nxt;
    logic [11:0]     r_pair_data, w_pair_data_nxt;
`else
    logic            r_last_b, w_last_b_nxt;
`endif

    function automatic logic [15:0] f_word(input logic [1:0] r, input logic [11:0] d);
        return {r[1], SPD, 1'b0, r[0], d};
    endfunction

    assign a_ready    = ~r_pend_a & ~rst;
    assign b_ready    = ~r_pend_b & ~rst;
    assign busy       = (r_state != S_IDLE);
    assign dac_sclk   = r_sclk;
    assign dac_din    = r_din;
    assign dac_csn    = r_csn;
    assign frame_done = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_bit_nxt   = r_bit;
        w_gcnt_nxt  = r_gcnt;
        w_sr_nxt    = r_sr;
        w_clr_a     = 1'b0;
        w_clr_b     = 1'b0;
        w_done_nxt  = 1'b0;
`ifdef SCHED_PAIR_EN
        w_pair_q_nxt    = r_pair_q;
        w_pair_data_nxt = r_pair_data;
`else
        w_last_b_nxt    = r_last_b;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_pend_a || r_pend_b) begin
                    w_state_nxt = S_LOAD;
`ifdef SCHED_PAIR_EN
                    // A is parked aside so its holding register can refill during the pair
                    if (r_pend_a && r_pend_b) begin
                        w_sr_nxt        = f_word(2'b01, r_b_data);
                        w_clr_a         = 1'b1;
                        w_clr_b         = 1'b1;
                        w_pair_q_nxt    = 1'b1;
                        w_pair_data_nxt = r_a_data;
                    end else if (r_pend_a) begin
                        w_sr_nxt = f_word(2'b10, r_a_data);
                        w_clr_a  = 1'b1;
                    end else begin
                        w_sr_nxt = f_word(2'b00, r_b_data);
                        w_clr_b  = 1'b1;
                    end
`else
                    if (r_pend_a && (!r_pend_b || r_last_b)) begin
                        w_sr_nxt     = f_word(2'b10, r_a_data);
                        w_clr_a      = 1'b1;
                        w_last_b_nxt = 1'b0;
                    end else begin
                        w_sr_nxt     = f_word(2'b00, r_b_data);
                        w_clr_b      = 1'b1;
                        w_last_b_nxt = 1'b1;
                    end
`endif
                end
            end
            S_LOAD: begin
                w_state_nxt = S_SHIFT;
                w_ph_nxt    = '0;
                w_bit_nxt   = '0;
            end
            S_SHIFT: begin
                if (r_ph == PHW'(2 * CLK_DIV - 1)) begin
                    w_ph_nxt = '0;
                    if (r_bit == 4'd15) begin
                        w_state_nxt = S_GAP;
                        w_gcnt_nxt  = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + 4'd1;
                        w_sr_nxt  = {r_sr[14:0], 1'b0};
                    end
                end else begin
                    w_ph_nxt = r_ph + PHW'(1);
                end
            end
            S_GAP: begin
                if (r_gcnt == GW'(CS_GAP - 1)) begin
                    w_state_nxt = S_IDLE;
`ifdef SCHED_PAIR_EN
                    if (r_pair_q) begin
                        w_state_nxt  = S_LOAD;
                        w_sr_nxt     = f_word(2'b10, r_pair_data);
                        w_pair_q_nxt = 1'b0;
                    end
`endif
                end else begin
                    w_gcnt_nxt = r_gcnt + GW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Pin values are registered from the next state so they change glitch-free on clk.
        w_csn_nxt  = !(w_state_nxt == S_LOAD || w_state_nxt == S_SHIFT);
        w_din_nxt  = w_csn_nxt ? 1'b0 : w_sr_nxt[15];
        w_sclk_nxt = !(w_state_nxt == S_SHIFT && w_ph_nxt >= PHW'(CLK_DIV));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ph     <= '0;
            r_bit    <= '0;
            r_gcnt   <= '0;
            r_sr     <= '0;
            r_pend_a <= 1'b0;
            r_pend_b <= 1'b0;
            r_a_data <= '0;
            r_b_data <= '0;
            r_sclk   <= 1'b1;
            r_din    <= 1'b0;
            r_csn    <= 1'b1;
            r_done   <= 1'b0;
`ifdef SCHED_PAIR_EN
            r_pair_q    <= 1'b0;
            r_pair_data <= '0;
`else
            r_last_b    <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
            r_bit   <= w_bit_nxt;
            r_gcnt  <= w_gcnt_nxt;
            r_sr    <= w_sr_nxt;
            r_sclk  <= w_sclk_nxt;
            r_din   <= w_din_nxt;
            r_csn   <= w_csn_nxt;
            r_done  <= w_done_nxt;
`ifdef SCHED_PAIR_EN
            r_pair_q    <= w_pair_q_nxt;
            r_pair_data <= w_pair_data_nxt;
`else
            r_last_b    <= w_last_b_nxt;
`endif
            if (w_clr_a) begin
                r_pend_a <= 1'b0;
            end else if (a_valid && a_ready) begin
                r_pend_a <= 1'b1;
                r_a_data <= a_data;
            end
            if (w_clr_b) begin
                r_pend_b <= 1'b0;
            end else if (b_valid && b_ready) begin
                r_pend_b <= 1'b1;
                r_b_data <= b_data;
            end
        end
    end

endmodule

// File: tb/tb_tlv5618a_sched.sv
// Scoreboard bench for tlv5618a_sched: accepted samples queue per channel, a pin-level
// monitor decodes each DAC frame and checks it against the queues and framing rules.
module tb_tlv5618a_sched;
    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned CS_GAP  = 2;
    localparam int unsigned LOW_CYC = 1 + 32 * CLK_DIV;
    localparam int unsigned BOUND   = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] a_data = '0, b_data = '0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic        dac_sclk, dac_din, dac_csn, busy, frame_done;

    tlv5618a_sched #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .SPD(1'b1)) dut (
        .clk(clk), .rst(rst),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .dac_sclk(dac_sclk), .dac_din(dac_din), .dac_csn(dac_csn),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [11:0] qa[$];
    logic [11:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- monitor ----------------
    logic        prev_sclk = 1'b1, prev_csn = 1'b1;
    int unsigned low_cnt = 0, high_cnt = 0, nbits = 0, frames = 0;
    logic [15:0] sh = '0;
    logic        last_ch_b = 1'b1;
    bit          strict = 1'b0, abort_flag = 1'b0, pair_open = 1'b0;

    always @(negedge clk) begin
        logic        is_a;
        logic [11:0] d;
        if (!dac_csn) begin
            if (prev_csn) begin
                low_cnt = 0; nbits = 0; sh = '0;
                if (pair_open) chk("pair_gap", high_cnt, CS_GAP);
                else if (frames > 0) chk("csn_gap_min", (high_cnt >= CS_GAP), 1);
            end
            low_cnt++;
            if (prev_sclk && !dac_sclk) begin
                sh = {sh[14:0], dac_din};
                nbits++;
            end
            if (frame_done) chk("frame_done_spurious", frame_done, 0);
        end else if (!prev_csn) begin
            high_cnt = 1;
            if (abort_flag) begin
                chk("frame_done_on_abort", frame_done, 0);
                abort_flag = 1'b0;
            end else begin
                frames++;
                chk("csn_low_len", low_cnt, LOW_CYC);
                chk("sclk_falls", nbits, 16);
                chk("frame_done", frame_done, 1);
                is_a = sh[15];
                if (is_a) begin
                    if (qa.size() == 0) chk("unexpected_a_frame", sh, 0);
                    else begin d = qa.pop_front(); chk("word_a", sh, {4'hC, d}); end
                    if (pair_open) chk("pair_second_is_a", is_a, 1);
                    pair_open = 1'b0;
                end else begin
                    if (pair_open) chk("pair_second_is_a", is_a, 1);
                    pair_open = 1'b0;
                    if (qb.size() == 0) chk("unexpected_b_frame", sh, 0);
                    else begin
                        d = qb.pop_front();
`ifdef SCHED_PAIR_EN
                        chk("word_b", sh, {(sh[12] ? 4'h5 : 4'h4), d});
                        pair_open = sh[12];
`else
                        chk("word_b", sh, {4'h4, d});
`endif
                    end
                end
                if (strict) chk("channel_order", is_a, last_ch_b);
                last_ch_b = !is_a;
            end
        end else begin
            high_cnt++;
            if (frame_done) chk("frame_done_spurious", frame_done, 0);
        end
        prev_sclk = dac_sclk;
        prev_csn  = dac_csn;
    end

    // ---------------- drivers ----------------
    task automatic drive_a(input logic [11:0] d);
        int unsigned t = 0;
        a_data = d; a_valid = 1'b1;
        while (!a_ready && t < BOUND) begin @(negedge clk); t++; end
        if (!a_ready) begin chk("a_ready_timeout", 0, 1); a_valid = 1'b0; return; end
        @(posedge clk);
        qa.push_back(d);
        @(negedge clk);
        a_valid = 1'b0;
        chk("a_ready_after_accept", a_ready, 0);
    endtask

    task automatic drive_b(input logic [11:0] d);
        int unsigned t = 0;
        b_data = d; b_valid = 1'b1;
        while (!b_ready && t < BOUND) begin @(negedge clk); t++; end
        if (!b_ready) begin chk("b_ready_timeout", 0, 1); b_valid = 1'b0; return; end
        @(posedge clk);
        qb.push_back(d);
        @(negedge clk);
        b_valid = 1'b0;
        chk("b_ready_after_accept", b_ready, 0);
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        @(negedge clk);
        while ((qa.size() != 0 || qb.size() != 0 || busy) && t < BOUND) begin
            @(negedge clk); t++;
        end
        chk("drain_timeout", (t < BOUND), 1);
        chk("ready_a_idle", a_ready, 1);
        chk("ready_b_idle", b_ready, 1);
    endtask

    task automatic stream_a(input int unsigned n, input int unsigned max_gap);
        for (int unsigned i = 0; i < n; i++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            drive_a(12'($urandom));
        end
    endtask

    task automatic stream_b(input int unsigned n, input int unsigned max_gap);
        for (int unsigned i = 0; i < n; i++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            drive_b(12'($urandom));
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_csn", dac_csn, 1);
        chk("rst_sclk", dac_sclk, 1);
        chk("rst_din", dac_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_a_ready", a_ready, 1);
        chk("post_rst_b_ready", b_ready, 1);

        drive_a(12'hABC);
        wait_idle();
        drive_b(12'h123);
        wait_idle();

        // both channels kept permanently offered
`ifdef SCHED_PAIR_EN
        last_ch_b = 1'b0;
`endif
        strict = 1'b1;
        fork
            stream_a(10, 0);
            stream_b(10, 0);
        join
        wait_idle();
        strict = 1'b0;

        fork
            stream_a(16, 80);
            stream_b(16, 80);
        join
        wait_idle();

        // reset in the middle of a frame, with B pending behind it
        @(negedge clk);
        drive_a(12'h5A5);
        begin
            int unsigned t = 0;
            while (dac_csn && t < BOUND) begin @(negedge clk); t++; end
            chk("csn_fall_timeout", dac_csn, 0);
        end
        drive_b(12'h3C3);
        repeat (7 * 2 * CLK_DIV - 1) @(negedge clk);
        abort_flag = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_csn", dac_csn, 1);
        chk("abort_sclk", dac_sclk, 1);
        chk("abort_din", dac_din, 0);
        chk("abort_busy", busy, 0);
        chk("abort_frame_done", frame_done, 0);
        chk("abort_a_ready", a_ready, 0);
        qa.delete();
        qb.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_pend_a_cleared", a_ready, 1);
        chk("abort_pend_b_cleared", b_ready, 1);
        repeat (200) @(negedge clk);
        chk("abort_no_frame", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        n_checks++;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
